// File: rtl/decoder_strobe_if.sv
// decoder_strobe_if
//   Groups the request/strobe signals of decoder_strobe so that sequencer
//   logic and the decoder connect through one bundle.
//   master : sequencer side, drives in/enable/start/clr_overrun and
//            observes out/busy/done/overrun.
//   slave  : decoder side, the mirror image.
//   Signals:
//     in          [SEL_WIDTH-1:0]  select code
//     enable      [1:0]            any bit high disables the decoder
//     start                        strobe request
//     clr_overrun                  clears the sticky overrun flag
//     out         [2^SEL_WIDTH-1:0] active-low one-of-N strobe lines
//     busy                         decoder not idle
//     done                         one-cycle pulse on return to idle
//     overrun                      sticky dropped-request flag
interface decoder_strobe_if #(
  parameter int SEL_WIDTH = 3
);
  localparam int OUT_W = 1 << SEL_WIDTH;

  logic [SEL_WIDTH-1:0] in;
  logic [1:0]           enable;
  logic                 start;
  logic                 clr_overrun;
  logic [OUT_W-1:0]     out;
  logic                 busy;
  logic                 done;
  logic                 overrun;

  modport master (
    output in, enable, start, clr_overrun,
    input  out, busy, done, overrun
  );

  modport slave (
    input  in, enable, start, clr_overrun,
    output out, busy, done, overrun
  );
endinterface

// File: rtl/decoder_strobe.sv
// decoder_strobe
//   Clocked binary-to-one-of-2^SEL_WIDTH decoder with active-low outputs.
//   An accepted start latches the select code and drives exactly one line
//   low for PULSE_CYCLES cycles, followed by GAP_CYCLES all-high cycles
//   before the next request can be accepted. All outputs are registered so
//   the strobe lines never glitch.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high; clears all state
//     bus    decoder_strobe_if.slave (in, enable, start, clr_overrun ->
//            out, busy, done, overrun)
module decoder_strobe #(
  parameter int SEL_WIDTH    = 3,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic            clk,
  input  logic            reset,
  decoder_strobe_if.slave bus
);

  localparam int OUT_W   = 1 << SEL_WIDTH;
  localparam int PG_MAX  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (PG_MAX > 2) ? PG_MAX : 2;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STROBE = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  logic [1:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [SEL_WIDTH-1:0] r_sel;
  logic [OUT_W-1:0]     r_out;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_overrun;

  logic w_dis;
  logic w_accept;
  logic w_ovr_set;

  // All ones except the selected line, which is pulled low.
  function automatic logic [OUT_W-1:0] f_strobe_pattern(input logic [SEL_WIDTH-1:0] sel);
    logic [OUT_W-1:0] v;
    v      = '1;
    v[sel] = 1'b0;
    return v;
  endfunction

  assign w_dis     = bus.enable[0] | bus.enable[1];
  assign w_accept  = bus.start && !w_dis && (r_state == ST_IDLE);
  // A request is dropped (and flagged) whenever it cannot be accepted.
  assign w_ovr_set = bus.start && ((r_state != ST_IDLE) || w_dis);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_sel     <= '0;
      r_out     <= '1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // Set has priority over clear on the same edge.
      if (w_ovr_set)
        r_overrun <= 1'b1;
      else if (bus.clr_overrun)
        r_overrun <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_out  <= '1;
          r_busy <= 1'b0;
          if (w_accept) begin
            r_sel   <= bus.in;
            r_cnt   <= PULSE_LOAD;
            r_out   <= f_strobe_pattern(bus.in);
            r_busy  <= 1'b1;
            r_state <= ST_STROBE;
          end
        end

        ST_STROBE: begin
          // Normal expiry and abort both go through the recovery gap.
          if (w_dis || (r_cnt == '0)) begin
            r_out <= '1;
            if (GAP_CYCLES > 0) begin
              r_cnt   <= GAP_LOAD;
              r_busy  <= 1'b1;
              r_state <= ST_GAP;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt  <= r_cnt - 1'b1;
            r_out  <= f_strobe_pattern(r_sel);
            r_busy <= 1'b1;
          end
        end

        ST_GAP: begin
          r_out <= '1;
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt  <= r_cnt - 1'b1;
            r_busy <= 1'b1;
          end
        end

        default: begin
          r_out   <= '1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.out     = r_out;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.overrun = r_overrun;

endmodule

// File: doc/decoder_strobe.md
# decoder_strobe

Parametrised, clocked binary-to-one-of-2^N decoder with active-low outputs and timed strobe generation. It is the sequential successor to the ECL-style 3-to-8 decoder. A select code is accepted on a start request; exactly one active-low line is then driven for a fixed number of cycles, followed by a guaranteed all-high recovery gap. It sits between sequencer control logic and the chip-select / register-strobe lines of the datapath, where raw combinational decode would glitch.

## Interface
- SEL_WIDTH, 3, select code width (≥1); output width OUT_W = 2^SEL_WIDTH
- PULSE_CYCLES, 2, cycles the selected output is held low (≥1)
- GAP_CYCLES, 1, all-high cycles enforced after every strobe (≥0)

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- in  in  SEL_WIDTH  select code, sampled only on an accepted start
- enable  in  2  active-high disables; master disable = enable[0] | enable[1]
- start  in  1  strobe request, level-sampled each edge
- clr_overrun  in  1  clears the overrun flag
- out  out  OUT_W  registered, active-low; bit `in` low while strobing
- busy  out  1  registered; high whenever state ≠ IDLE
- done  out  1  registered one-cycle pulse on return to IDLE
- overrun  out  1  sticky; set when start is seen while busy or disabled

## Operation
- Reset (synchronous, active-high) applies on any edge where reset=1, including mid-strobe. After it: state IDLE, out all ones, busy=0, done=0, overrun=0, latched select=0, counter=0.
- FSM states are IDLE, STROBE, GAP.
- **IDLE**
  - start=1 with master disable=0 → latch `in`, load counter with PULSE_CYCLES-1, go to STROBE.
  - start=1 with master disable=1 → stay in IDLE and set overrun.
- **STROBE**
  - out = all ones except bit[latched select]=0.
  - Counter decrements each cycle. At 0: go to GAP if GAP_CYCLES>0 (load counter with GAP_CYCLES-1), else go to IDLE.
- **GAP**
  - out all ones.
  - Counter decrements each cycle; at 0 go to IDLE.
- **Abort:** master disable=1 in STROBE → next edge out all ones and go to GAP (or IDLE if GAP_CYCLES=0). The gap is always honoured.
- **In IDLE or GAP**, out is all ones. At no time is more than one bit low.
- Changes to `in` after acceptance are ignored. Only the latched code drives out.
- start while busy=1 is dropped and sets overrun. No queueing.
- clr_overrun clears overrun. If set and clear happen on the same edge, set wins.
- done=1 for exactly one cycle following the edge that enters IDLE from STROBE or GAP. This covers both normal completion and abort. done is never asserted by reset.
- Counter width is clog2(max(PULSE_CYCLES, GAP_CYCLES, 2)). No wrap: the counter is reloaded before each use.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- start accepted at edge k:
  - out[sel] is low and busy=1 in cycles k+1 … k+PULSE_CYCLES.
  - out is all ones in cycles k+PULSE_CYCLES+1 … k+PULSE_CYCLES+GAP_CYCLES.
  - IDLE is reached, with done=1 and busy=0, at cycle k+PULSE_CYCLES+GAP_CYCLES+1.
- Earliest next accept is at edge k+PULSE_CYCLES+GAP_CYCLES+1. This gives a back-to-back period of PULSE_CYCLES+GAP_CYCLES+1 cycles.
- Abort: master disable high at edge m during STROBE → out all ones from cycle m+1. Gap runs m+1 … m+GAP_CYCLES.
- overrun rises the cycle after the offending edge.

## Test plan
- **Reset:** hold reset 2 cycles with start=1, in=5 → out=8'hFF, busy=0, done=0, overrun=0 throughout, and for the first cycle after release.
- **Basic strobe** (defaults): in=3, start pulse at edge k → out=8'hF7 for cycles k+1, k+2; 8'hFF at k+3; done=1 and busy=0 at k+4. Sweep all 8 codes.
- **Latch and overrun:** accept in=6, change in to 1 and raise start during STROBE → out stays 8'hBF, overrun=1, no second strobe. clr_overrun=1 together with a new busy start → overrun stays 1.
- **Abort:** in=0 accepted, enable=2'b10 on the first STROBE cycle → out=8'hFF next cycle, one gap cycle, done pulse. start with enable≠0 in IDLE → overrun=1, out stays 8'hFF.
- **Parameter corners:** SEL_WIDTH=4, PULSE_CYCLES=1, GAP_CYCLES=0, start held high continuously, in=15 → out=16'h7FFF for 1 cycle every 2 cycles, never two bits low.
- **Reset mid-strobe:** reset during cycle 2 of a PULSE_CYCLES=4 strobe → next cycle out all ones, busy=0, no done pulse.
